etc1_block_stream: RTL

ETC1_BLOCK_STREAM -- requirements
Module: etc1_block_stream

---
 rtl/etc1_block_stream.sv | 70 +++++++
 1 files changed

// File: rtl/etc1_block_stream.sv
// rtl/etc1_block_stream.sv - Streams one 64-bit ETC1 block as 16 RGB888 pixels through an external decoder.
module etc1_block_stream #(
    parameter bit COL_MAJOR = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] blk_data,
    input  logic        blk_valid,
    output logic        blk_ready,
    output logic [63:0] dec_block,
    output logic [2:0]  dec_x,
    output logic [2:0]  dec_y,
    input  logic [23:0] dec_pixel,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last,
    output logic        busy
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [3:0]  idx;
    logic [63:0] blk_reg;
    logic        out_free;
    logic        issue;
    logic        last_issue;

    assign out_free   = !pix_valid || pix_ready;
    assign issue      = (state == RUN) && out_free;
    assign last_issue = issue && (idx == 4'd15);

    // Accepting on the last issue lets back-to-back blocks stream with no bubble.
    assign blk_ready = !reset && ((state == IDLE) || last_issue);
    assign busy      = (state == RUN) || pix_valid;
    assign dec_block = blk_reg;
    assign dec_x     = COL_MAJOR ? {1'b0, idx[3:2]} : {1'b0, idx[1:0]};
    assign dec_y     = COL_MAJOR ? {1'b0, idx[1:0]} : {1'b0, idx[3:2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 4'd0;
            blk_reg   <= 64'd0;
            pix_data  <= 24'd0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
        end else begin
            if (issue) begin
                pix_data  <= dec_pixel;
                pix_valid <= 1'b1;
                pix_last  <= (idx == 4'd15);
                idx       <= idx + 4'd1;
            end else if (pix_valid && pix_ready) begin
                pix_valid <= 1'b0;
                pix_last  <= 1'b0;
            end

            if (blk_valid && blk_ready) begin
                blk_reg <= blk_data;
                idx     <= 4'd0;
                state   <= RUN;
            end else if (last_issue) begin
                state <= IDLE;
            end
        end
    end

endmodule
